// File: rtl/move_checker_if.sv
// Request/response bundle between the movement controller and move_checker,
// including the occupancy grid that must stay stable while a check is in flight.
interface move_checker_if #(
  parameter int COLS  = 10,
  parameter int ROWS  = 30,
  parameter int ROW_W = 5,
  parameter int COL_W = 5
);
  logic                   req_valid;
  logic                   req_ready;
  logic [15:0]            req_mask;
  logic [ROW_W-1:0]       req_row;
  logic [COL_W-1:0]       req_col;
  logic [COLS*ROWS-1:0]   grid;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_blocked;
  logic [1:0]             resp_cause;

  modport master (
    output req_valid, req_mask, req_row, req_col, grid, resp_ready,
    input  req_ready, resp_valid, resp_blocked, resp_cause
  );

  modport slave (
    input  req_valid, req_mask, req_row, req_col, grid, resp_ready,
    output req_ready, resp_valid, resp_blocked, resp_cause
  );
endinterface

// File: rtl/move_checker.sv
// Row-serial collision checker for a 4x4 piece mask against walls, floor and grid.
// Define MOVE_CHECK_EARLY_EXIT_EN to stop scanning at the first colliding mask row.
module move_checker #(
  parameter int COLS  = 10,
  parameter int ROWS  = 30,
  parameter int ROW_W = 5,
  parameter int COL_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  move_checker_if.slave  io_bus
);

`ifdef MOVE_CHECK_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif
  localparam int IDX_W = $clog2(COLS*ROWS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_mask;
  logic [ROW_W-1:0]     r_row;
  logic [COL_W-1:0]     r_col;
  logic [1:0]           r_k;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic                 r_blocked;
  logic [1:0]           r_cause;

  logic [3:0]           w_row_bits;
  logic [ROW_W:0]       w_abs_row;
  logic                 w_floor_row;
  logic signed [COL_W:0] w_col_ext;
  logic signed [COL_W:0] w_abs_col [4];
  logic [IDX_W-1:0]     w_idx [4];
  logic [3:0]           w_col_oob;
  logic [3:0]           w_wall;
  logic [3:0]           w_floor;
  logic [3:0]           w_cell;
  logic                 w_hit;
  logic [1:0]           w_cause;

  assign w_row_bits  = r_mask[{r_k, 2'b00} +: 4];
  assign w_abs_row   = {1'b0, r_row} + {{(ROW_W-1){1'b0}}, r_k};
  assign w_floor_row = (w_abs_row >= (ROW_W+1)'(ROWS));
  assign w_col_ext   = $signed({r_col[COL_W-1], r_col});

  // Grid lookup is only formed for in-bounds cells so the index never leaves the grid.
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign w_abs_col[c] = w_col_ext + $signed((COL_W+1)'(c));
    assign w_col_oob[c] = w_abs_col[c][COL_W] ||
                          (w_abs_col[c] >= $signed((COL_W+1)'(COLS)));
    assign w_idx[c]     = (!w_col_oob[c] && !w_floor_row)
                          ? (IDX_W'(w_abs_row) * IDX_W'(COLS) + IDX_W'(w_abs_col[c]))
                          : {IDX_W{1'b0}};
    assign w_wall[c]    = w_row_bits[c] & w_col_oob[c];
    assign w_floor[c]   = w_row_bits[c] & w_floor_row;
    assign w_cell[c]    = w_row_bits[c] & ~w_col_oob[c] & ~w_floor_row & io_bus.grid[w_idx[c]];
  end

  assign w_hit = (|w_wall) | (|w_floor) | (|w_cell);

  // Cause priority across the whole mask row: wall, then floor, then occupied cell.
  always_comb begin
    w_cause = 2'b00;
    if (|w_wall) begin
      w_cause = 2'b01;
    end else if (|w_floor) begin
      w_cause = 2'b10;
    end else if (|w_cell) begin
      w_cause = 2'b11;
    end else begin
      w_cause = 2'b00;
    end
  end

  // Next-state logic for IDLE -> SCAN -> RESP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_bus.req_valid) w_state_nxt = S_SCAN;
        else                  w_state_nxt = S_IDLE;
      end
      S_SCAN: begin
        if ((w_hit && EARLY_EXIT) || (r_k == 2'd3)) w_state_nxt = S_RESP;
        else                                        w_state_nxt = S_SCAN;
      end
      S_RESP: begin
        if (io_bus.resp_ready) w_state_nxt = S_IDLE;
        else                   w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, latched request, row index and verdict registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mask       <= 16'h0000;
      r_row        <= {ROW_W{1'b0}};
      r_col        <= {COL_W{1'b0}};
      r_k          <= 2'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_blocked    <= 1'b0;
      r_cause      <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid) begin
            r_mask    <= io_bus.req_mask;
            r_row     <= io_bus.req_row;
            r_col     <= io_bus.req_col;
            r_k       <= 2'd0;
            r_blocked <= 1'b0;
            r_cause   <= 2'b00;
          end
        end
        S_SCAN: begin
          // First colliding row owns the verdict; later rows are ignored.
          if (w_hit && !r_blocked) begin
            r_blocked <= 1'b1;
            r_cause   <= w_cause;
          end
          if (w_state_nxt == S_SCAN) r_k <= r_k + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.req_ready    = r_req_ready;
  assign io_bus.resp_valid   = r_resp_valid;
  assign io_bus.resp_blocked = r_blocked;
  assign io_bus.resp_cause   = r_cause;

endmodule

// File: tb/tb_move_checker.sv
// Scoreboard bench for move_checker: directed scenarios plus randomized moves,
// checked against a cell-by-cell reference model.
module tb_move_checker;
  localparam int COLS  = 10;
  localparam int ROWS  = 30;
  localparam int ROW_W = 5;
  localparam int COL_W = 5;
`ifdef MOVE_CHECK_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic       blocked;
    logic [1:0] cause;
    int         lat;
    int         acc;
    int         stall;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   issued   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  move_checker_if #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .COL_W(COL_W)) ifc();

  move_checker #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk each mask cell, classify it, first colliding row wins.
  function automatic void model(input logic [15:0] m, input int r, input int c,
                                input logic [COLS*ROWS-1:0] g,
                                output logic b, output logic [1:0] cs, output int lat);
    bit wl, fl, ce;
    int ar, ac;
    b = 1'b0; cs = 2'b00; lat = 4;
    for (int k = 0; k < 4; k++) begin
      wl = 1'b0; fl = 1'b0; ce = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (m[4*k+j]) begin
          ar = r + k;
          ac = c + j;
          if (ac < 0 || ac >= COLS) wl = 1'b1;
          if (ar >= ROWS) fl = 1'b1;
          if (ac >= 0 && ac < COLS && ar < ROWS && g[ar*COLS+ac]) ce = 1'b1;
        end
      end
      if (wl || fl || ce) begin
        b   = 1'b1;
        cs  = wl ? 2'b01 : (fl ? 2'b10 : 2'b11);
        lat = EARLY ? k + 1 : 4;
        return;
      end
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (done_cnt != issued && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt != issued) begin
      chk("response_timeout", done_cnt, issued);
      sb.delete();
      done_cnt = issued;
    end
  endtask

  task automatic issue(input logic [15:0] m, input logic [4:0] r, input logic [4:0] c,
                       input logic [COLS*ROWS-1:0] g, input int stall, input bit track);
    exp_t e;
    int n = 0;
    wait_idle();
    @(negedge clk);
    ifc.grid      = g;
    ifc.req_mask  = m;
    ifc.req_row   = r;
    ifc.req_col   = c;
    ifc.req_valid = 1'b1;
    while (!ifc.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
    if (track) begin
      model(m, int'(r), int'($signed(c)), g, e.blocked, e.cause, e.lat);
      e.acc   = cyc;
      e.stall = stall;
      sb.push_back(e);
      issued++;
    end
  endtask

  // Monitor: pops the oldest expectation whenever a verdict appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 1, 0);
          ifc.resp_ready = 1'b1;
          @(posedge clk);
          #1 ifc.resp_ready = 1'b0;
        end else begin
          e = sb.pop_front();
          chk("blocked", int'(ifc.resp_blocked), int'(e.blocked));
          chk("cause",   int'(ifc.resp_cause),   int'(e.cause));
          chk("latency", cyc - e.acc,            e.lat);
          for (int i = 0; i < e.stall; i++) begin
            @(negedge clk);
            chk("hold_valid",   int'(ifc.resp_valid),   1);
            chk("hold_blocked", int'(ifc.resp_blocked), int'(e.blocked));
            chk("hold_cause",   int'(ifc.resp_cause),   int'(e.cause));
            chk("hold_ready0",  int'(ifc.req_ready),    0);
          end
          ifc.resp_ready = 1'b1;
          @(posedge clk);
          #1 ifc.resp_ready = 1'b0;
          @(negedge clk);
          chk("post_valid", int'(ifc.resp_valid), 0);
          chk("post_ready", int'(ifc.req_ready),  1);
          done_cnt++;
        end
      end
    end
  end

  initial begin
    logic [COLS*ROWS-1:0] g;
    logic [15:0] m;
    int seen;
    ifc.req_valid  = 1'b0;
    ifc.req_mask   = 16'h0000;
    ifc.req_row    = 5'd0;
    ifc.req_col    = 5'd0;
    ifc.grid       = '0;
    ifc.resp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  int'(ifc.req_ready),    1);
    chk("rst_resp_valid", int'(ifc.resp_valid),   0);
    chk("rst_blocked",    int'(ifc.resp_blocked), 0);
    chk("rst_cause",      int'(ifc.resp_cause),   0);
    rst_n = 1'b1;

    g = '0;
    issue(16'h0033, 5'd10, 5'd4,    g, 0, 1'b1);
    issue(16'h0033, 5'd10, 5'h1F,   g, 0, 1'b1);
    issue(16'h0033, 5'd29, 5'd4,    g, 0, 1'b1);
    g[125] = 1'b1;
    issue(16'h0033, 5'd11, 5'd4,    g, 0, 1'b1);
    g = '0;
    issue(16'h0033, 5'd29, 5'd9,    g, 0, 1'b1);
    issue(16'h0000, 5'd31, 5'h1F,   g, 0, 1'b1);
    issue(16'h0033, 5'd10, 5'd4,    g, 3, 1'b1);
    wait_idle();

    // Abort a scan with reset: no verdict may follow.
    issue(16'h0033, 5'd10, 5'd4, g, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready",  int'(ifc.req_ready),    1);
    chk("abort_resp_valid", int'(ifc.resp_valid),   0);
    chk("abort_blocked",    int'(ifc.resp_blocked), 0);
    chk("abort_cause",      int'(ifc.resp_cause),   0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.resp_valid) seen++;
    end
    chk("abort_no_resp", seen, 0);
    issue(16'h0033, 5'd10, 5'd4, g, 0, 1'b1);

    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < COLS*ROWS; i++) g[i] = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      issue(m, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), g,
            $urandom_range(0, 3), 1'b1);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
